// File: rtl/pc_fetch_seq.sv
// ============================================================================
// Module   : pc_fetch_seq
// Brief    : Program-counter and fetch sequencer. Owns the instruction
//            address, advances it each RUN cycle, loads absolute branch
//            targets from the branch lookup table, and runs an
//            IDLE/RUN/HALTED launch-and-completion state machine.
//            Optional feature macro: PC_LINK_EN (branch-and-link / return).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_seq #(
  parameter int unsigned PC_W       = 12,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_pos,
`ifdef PC_LINK_EN
  input  logic             link,
  input  logic             ret,
`endif
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic             bad_branch,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [PC_W-1:0]  C_START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0]  C_PC_ONE   = PC_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  // Sequential incrementer shared by every "advance" path; wraps modulo 2^PC_W.
  logic [PC_W-1:0]  pc_inc;
  assign pc_inc = pc_q + C_PC_ONE;

  // A zero target marks an unmapped key in the branch lookup table.
  logic             target_valid;
  assign target_valid = (branch_pos != '0);

`ifdef PC_LINK_EN
  logic [PC_W-1:0]  link_q, link_d;
`endif

  // State, pc, counter and flag registers; reset forces IDLE asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= C_START_PC;
      cnt_q     <= '0;
      bad_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      bad_q     <= bad_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

`ifdef PC_LINK_EN
  // Link register captures the return address of a taken branch-and-link.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q <= '0;
    end else begin
      link_q <= link_d;
    end
  end
`endif

  // Next-state, next-pc and flag logic; RUN follows a fixed priority order.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
`ifdef PC_LINK_EN
    link_d  = link_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        // Launch (or relaunch) clears the run statistics.
        if (start) begin
          state_d = ST_RUN;
          pc_d    = C_START_PC;
          cnt_d   = '0;
          bad_d   = 1'b0;
        end
      end

      ST_RUN: begin
        // Every RUN cycle counts, stalls and the halting cycle included.
        if (cnt_q != C_CNT_MAX) begin
          cnt_d = cnt_q + C_CNT_ONE;
        end

        if (halt) begin
          state_d = ST_HALTED;
        end else if (stall) begin
          // Hold; a concurrent branch is dropped and must be re-presented.
          pc_d = pc_q;
`ifdef PC_LINK_EN
        end else if (ret) begin
          pc_d = link_q;
`endif
        end else if (branch_taken && target_valid) begin
          pc_d = branch_pos;
`ifdef PC_LINK_EN
          if (link) begin
            link_d = pc_inc;
          end
`endif
        end else if (branch_taken) begin
          bad_d = 1'b1;
          pc_d  = pc_inc;
        end else begin
          pc_d = pc_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered alongside the state so they move together.
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_HALTED);
  end

  assign pc          = pc_q;
  assign running     = running_q;
  assign done        = done_q;
  assign bad_branch  = bad_q;
  assign cycle_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_seq.sv
`default_nettype none

module tb_pc_fetch_seq;

  localparam int PC_MOD  = 4096;
  localparam int CNT_MAX = 65535;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        stall;
  logic        branch_taken;
  logic [11:0] branch_pos;
`ifdef PC_LINK_EN
  logic        link;
  logic        ret;
`endif
  logic [11:0] pc;
  logic        running;
  logic        done;
  logic        bad_branch;
  logic [15:0] cycle_count;

  int tests_run = 0;
  int tests_failed = 0;

  pc_fetch_seq #(
    .PC_W       (12),
    .START_ADDR (0),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .halt         (halt),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pos   (branch_pos),
`ifdef PC_LINK_EN
    .link         (link),
    .ret          (ret),
`endif
    .pc           (pc),
    .running      (running),
    .done         (done),
    .bad_branch   (bad_branch),
    .cycle_count  (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Reference model: mode is 0 = idle, 1 = run, 2 = halted.
  // ---------------------------------------------------------------------
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;
  int m_bad  = 0;
  int m_link = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_pc   <= 0;
      m_cnt  <= 0;
      m_bad  <= 0;
      m_link <= 0;
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode <= 1;
        m_pc   <= 0;
        m_cnt  <= 0;
        m_bad  <= 0;
      end
    end else begin
      m_cnt <= (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (halt) begin
        m_mode <= 2;
      end else if (stall) begin
        m_pc <= m_pc;
`ifdef PC_LINK_EN
      end else if (ret) begin
        m_pc <= m_link;
`endif
      end else if (branch_taken && int'(branch_pos) != 0) begin
        m_pc <= int'(branch_pos);
`ifdef PC_LINK_EN
        if (link) m_link <= (m_pc + 1) % PC_MOD;
`endif
      end else begin
        if (branch_taken) m_bad <= 1;
        m_pc <= (m_pc + 1) % PC_MOD;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model.pc",      int'(pc),          m_pc);
    check("model.running", int'(running),     (m_mode == 1) ? 1 : 0);
    check("model.done",    int'(done),        (m_mode == 2) ? 1 : 0);
    check("model.bad",     int'(bad_branch),  m_bad);
    check("model.count",   int'(cycle_count), m_cnt);
  end

  // One clock of stimulus; outputs are settled on return.
  task automatic cyc(input logic s, input logic h, input logic st,
                     input logic bt, input int pos);
    start        = s;
    halt         = h;
    stall        = st;
    branch_taken = bt;
    branch_pos   = 12'(pos);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    halt         = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_pos   = '0;
`ifdef PC_LINK_EN
    link         = 1'b0;
    ret          = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset.pc",      int'(pc), 0);
    check("reset.running", int'(running), 0);
    check("reset.done",    int'(done), 0);
    check("reset.bad",     int'(bad_branch), 0);
    check("reset.count",   int'(cycle_count), 0);
    rst_n = 1'b1;

    // Inputs other than start are ignored in IDLE.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 0);
    check("idle.ignore.pc", int'(pc), 0);
    check("idle.ignore.bad", int'(bad_branch), 0);

    // Launch and free-run five cycles.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("start.pc", int'(pc), 0);
    idle(5);
    check("run5.pc", int'(pc), 5);
    check("run5.count", int'(cycle_count), 5);
    check("run5.running", int'(running), 1);

    // Start during RUN is ignored.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("run.start_ignored.pc", int'(pc), 6);

    // Halt, then relaunch.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("halt.done", int'(done), 1);
    check("halt.pc", int'(pc), 6);
    check("halt.count", int'(cycle_count), 7);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    check("branch.pre", int'(pc), 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 68);
    check("branch.target", int'(pc), 68);
    idle(1);
    check("branch.next", int'(pc), 69);

    // Stall drops a concurrent branch.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 10);
    check("stall.pre", int'(pc), 10);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16);
    check("stall.hold1", int'(pc), 10);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16);
    check("stall.hold2", int'(pc), 10);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16);
    check("stall.branch", int'(pc), 16);
    check("stall.count", int'(cycle_count), 9);

    // Unmapped target: flag and fall through.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 7);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0);
    check("bad.pc", int'(pc), 8);
    check("bad.flag", int'(bad_branch), 1);
    idle(1);
    check("bad.sticky", int'(bad_branch), 1);

    // Increment wraps with no flag side effect.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4094);
    idle(1);
    check("wrap.4095", int'(pc), 4095);
    idle(1);
    check("wrap.0", int'(pc), 0);

    // Halt at 20; everything holds until start.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 20);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("halt20.done", int'(done), 1);
    check("halt20.running", int'(running), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 99);
    idle(1);
    check("halted.pc", int'(pc), 20);
    check("halted.bad", int'(bad_branch), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("restart.pc", int'(pc), 0);
    check("restart.done", int'(done), 0);
    check("restart.bad", int'(bad_branch), 0);
    check("restart.count", int'(cycle_count), 0);

    // Start and halt together in RUN: halt wins.
    idle(2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("start_halt.done", int'(done), 1);
    check("start_halt.pc", int'(pc), 2);

    // Asynchronous reset mid-run.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.running", int'(running), 0);
    check("async_rst.pc", int'(pc), 0);
    check("async_rst.count", int'(cycle_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    check("after_rst.idle", int'(running), 0);

`ifdef PC_LINK_EN
    // Branch-and-link, then return (return outranks a concurrent branch).
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(4);
    link = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 55);
    link = 1'b0;
    check("link.target", int'(pc), 55);
    idle(3);
    check("link.pre_ret", int'(pc), 58);
    ret = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 300);
    ret = 1'b0;
    check("ret.pc", int'(pc), 5);
`endif

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_fetch_seq.md
# pc_fetch_seq

Program-counter and fetch sequencer for the core. Owns the 12-bit instruction address and advances it each cycle. On a taken branch it loads the absolute target produced by the branch lookup table, one stage downstream of that table. It runs a small start/run/halt state machine that the testbench and top level use to launch a program and detect completion.

## Interface
- `PC_W`, 12: program counter width; must equal the branch-target width.
- `START_ADDR`, 0: address loaded on `start`.
- `CNT_W`, 16: width of the run-cycle counter.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  launch program; single-cycle pulse.
- `halt`  in  1  decoded DONE instruction at current `pc`.
- `stall`  in  1  hold `pc` this cycle.
- `branch_taken`  in  1  branch condition true for instruction at `pc`.
- `branch_pos`  in  PC_W  absolute target from the branch lookup table; 0 = unmapped key.
- `link`  in  1  branch-and-link qualifier; exists only with `PC_LINK_EN`.
- `ret`  in  1  return to the link address; exists only with `PC_LINK_EN`.
- `pc`  out  PC_W  current instruction address.
- `running`  out  1  high in RUN.
- `done`  out  1  high in HALTED.
- `bad_branch`  out  1  sticky flag: a taken branch had target 0.
- `cycle_count`  out  CNT_W  cycles spent in RUN.

## Operation
- States: IDLE, RUN, HALTED. Reset enters IDLE.
- **IDLE**
  - `start` loads `pc` with START_ADDR, clears `cycle_count` and `bad_branch`, and moves to RUN.
  - Other inputs are ignored.
- **RUN**, evaluated in priority order each cycle:
  1. `halt`: move to HALTED; `pc` holds.
  2. `stall`: `pc` holds.
  3. `ret`: `pc` loads the link register (PC_LINK_EN only).
  4. `branch_taken` with `branch_pos != 0`: `pc` loads `branch_pos`.
  5. `branch_taken` with `branch_pos == 0`: set `bad_branch`; `pc` increments.
  6. Otherwise `pc` increments.
- **RUN, other rules**
  - `start` is ignored.
  - `cycle_count` increments every RUN cycle, stalled cycles included; it saturates at all-ones.
- **HALTED**
  - `pc`, `cycle_count` and `bad_branch` hold.
  - `start` behaves as in IDLE and moves to RUN.
- **Arithmetic**
  - Increment is modulo 2^PC_W: 4095 + 1 = 0, with no flag.
  - `branch_pos` is used unmodified; no offset is added.
- **Reset**
  - Asserting `rst_n` low in any state, including mid-run, forces IDLE immediately, without waiting for a clock edge.

## Timing
- Reset values: `pc` = START_ADDR, `running` = 0, `done` = 0, `bad_branch` = 0, `cycle_count` = 0, link register = 0.
- All outputs are registered; none has a combinational path from the inputs.
- Inputs are sampled on the rising edge; the resulting `pc` is visible the following cycle, giving one-cycle latency from `branch_taken` to target.
- `running` and `done` change on the same edge as the state change.
- `start` and `halt` in the same RUN cycle: `halt` wins.
- `stall` and `branch_taken` together: the branch is dropped. Upstream must hold `branch_taken` until `stall` deasserts.
- Reset deassertion is synchronised to `clk` externally; no internal synchroniser.

## Configuration
- Macro: `PC_LINK_EN`.
- **Defined**
  - Adds ports `link` and `ret` and a PC_W link register.
  - A taken, non-stalled branch with a valid target and `link` = 1 stores `pc + 1` (mod 2^PC_W) in the link register on the same edge.
  - `ret` in RUN loads `pc` from the link register; `ret` outranks `branch_taken`.
- **Undefined**
  - No `link` or `ret` ports and no link register.
  - Priority list skips step 3.

## Test plan
- Reset, `start` pulse, 5 free-run cycles -> `pc` sequence 0,1,2,3,4,5; `running` = 1; `cycle_count` = 5.
- At `pc` = 3, `branch_taken` = 1 with `branch_pos` = 68 -> `pc` = 68 next cycle, then 69.
- At `pc` = 10, `stall` = 1 together with `branch_taken` (target 16) for 2 cycles, then branch only -> `pc` 10,10,10,16. `cycle_count` includes the stalls.
- `branch_taken` with `branch_pos` = 0 at `pc` = 7 -> `pc` = 8 and `bad_branch` = 1, sticky until next `start`.
- `halt` at `pc` = 20 -> HALTED, `done` = 1, `pc` holds 20. `start` -> `pc` = 0, `done` = 0. `rst_n` low mid-run -> IDLE immediately.
- `PC_LINK_EN`: branch with `link` at `pc` = 4 to 55 -> link register = 5. `ret` at `pc` = 58 -> `pc` = 5.
